compound_dispatch_n: RTL and testbench

- Parametrised successor of the single-channel compound-type sectioned block.
- Samples a compound {mode, x, y} record from a master input every cycle in its idle section.
- Accumulates x on write-mode records.
- Delivers the result over NUM_CH blocking sync/notify output channels, either round-robin or broadcast.
- Sits between a producer of compound records and several blocking consumers in generated-property designs.

---
 rtl/compound_dispatch_n.sv | 115 +++++++++++
 tb/tb_compound_dispatch_n.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/compound_dispatch_n.sv
// Samples {mode, x, y} records, accumulates x on writes and hands each result
// to NUM_CH blocking sync/notify consumers, round-robin or broadcast.
module compound_dispatch_n #(
  parameter int NUM_CH    = 4,
  parameter int X_WIDTH   = 32,
  parameter int BROADCAST = 0,
  localparam int PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_in_mode,
  input  logic [X_WIDTH-1:0] m_in_x,
  input  logic               m_in_y,
  output logic               b_out_mode,
  output logic [X_WIDTH-1:0] b_out_x,
  output logic               b_out_y,
  output logic [NUM_CH-1:0]  b_out_notify,
  input  logic [NUM_CH-1:0]  b_out_sync,
  output logic [PTR_W-1:0]   ch_ptr,
  output logic [15:0]        sent_count
);

  // state     | meaning
  // SECTION_A | sample master record every cycle; a write launches delivery
  // SECTION_B | hold record, wait for consumer sync on notified channel(s)
  typedef enum logic {SECTION_A = 1'b0, SECTION_B = 1'b1} section_e;

  section_e             state_q, state_d;
  logic                 rec_mode_q, rec_mode_d;
  logic [X_WIDTH-1:0]   rec_x_q, rec_x_d;
  logic                 rec_y_q, rec_y_d;
  logic [NUM_CH-1:0]    notify_q, notify_d;
  logic [NUM_CH-1:0]    done_q, done_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [NUM_CH-1:0]    comp;
  logic [NUM_CH-1:0]    done_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SECTION_A;
      rec_mode_q <= 1'b0;
      rec_x_q    <= '0;
      rec_y_q    <= 1'b0;
      notify_q   <= '0;
      done_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rec_mode_q <= rec_mode_d;
      rec_x_q    <= rec_x_d;
      rec_y_q    <= rec_y_d;
      notify_q   <= notify_d;
      done_q     <= done_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rec_mode_d = rec_mode_q;
    rec_x_d    = rec_x_q;
    rec_y_d    = rec_y_q;
    notify_d   = notify_q;
    done_d     = done_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    // sync is only meaningful on channels currently being notified
    comp       = notify_q & b_out_sync;
    done_all   = done_q | comp;

    case (state_q)
      SECTION_A: begin
        rec_y_d    = m_in_y;
        rec_mode_d = m_in_mode;
        if (m_in_mode) begin
          rec_x_d = rec_x_q + m_in_x;
          state_d = SECTION_B;
          if (BROADCAST != 0) begin
            notify_d = '1;
            done_d   = '0;
          end else begin
            notify_d = NUM_CH'(1) << ptr_q;
          end
        end
      end
      SECTION_B: begin
        notify_d = notify_q & ~comp;
        if (BROADCAST != 0) begin
          done_d = done_all;
          if (&done_all) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = SECTION_A;
          end
        end else if (|comp) begin
          ptr_d   = (ptr_q == PTR_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = SECTION_A;
        end
      end
      default: state_d = SECTION_A;
    endcase
  end

  assign b_out_mode   = rec_mode_q;
  assign b_out_x      = rec_x_q;
  assign b_out_y      = rec_y_q;
  assign b_out_notify = notify_q;
  assign ch_ptr       = ptr_q;
  assign sent_count   = cnt_q;

endmodule

// File: tb/tb_compound_dispatch_n.sv
// Directed plus randomized checks of a round-robin and a broadcast instance
// against a transaction-level reference model.
module tb_compound_dispatch_n;

  localparam int NCH = 4;
  localparam int XW  = 8;

  logic          clk = 1'b0;
  logic          rst;

  logic          mode_a, y_a;
  logic [XW-1:0] x_a;
  logic          omode_a, oy_a;
  logic [XW-1:0] ox_a;
  logic [NCH-1:0] notify_a, sync_a;
  logic [1:0]    ptr_a;
  logic [15:0]   cnt_a;

  logic          mode_b, y_b;
  logic [XW-1:0] x_b;
  logic          omode_b, oy_b;
  logic [XW-1:0] ox_b;
  logic [NCH-1:0] notify_b, sync_b;
  logic [1:0]    ptr_b;
  logic [15:0]   cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int m_acc, m_ptr, m_cnt, m_y;

  always #5 clk = ~clk;

  compound_dispatch_n #(.NUM_CH(NCH), .X_WIDTH(XW), .BROADCAST(0)) u_rr (
    .clk(clk), .rst(rst),
    .m_in_mode(mode_a), .m_in_x(x_a), .m_in_y(y_a),
    .b_out_mode(omode_a), .b_out_x(ox_a), .b_out_y(oy_a),
    .b_out_notify(notify_a), .b_out_sync(sync_a),
    .ch_ptr(ptr_a), .sent_count(cnt_a)
  );

  compound_dispatch_n #(.NUM_CH(NCH), .X_WIDTH(XW), .BROADCAST(1)) u_bc (
    .clk(clk), .rst(rst),
    .m_in_mode(mode_b), .m_in_x(x_b), .m_in_y(y_b),
    .b_out_mode(omode_b), .b_out_x(ox_b), .b_out_y(oy_b),
    .b_out_notify(notify_b), .b_out_sync(sync_b),
    .ch_ptr(ptr_b), .sent_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_acc = 0; m_ptr = 0; m_cnt = 0; m_y = 0;
  endtask

  // one round-robin record with consumer stall of 'stall' cycles
  task automatic rr_record(input int xv, input int stall);
    logic [NCH-1:0] onehot;
    mode_a = 1'b1; x_a = XW'(xv); y_a = 1'($urandom);
    m_y = int'(y_a);
    tick();
    m_acc = (m_acc + xv) % 256;
    onehot = NCH'(1) << m_ptr;
    check("rr_notify_rise", 32'(notify_a), 32'(onehot));
    check("rr_x", 32'(ox_a), 32'(m_acc));
    check("rr_mode_y", {omode_a, oy_a}, {1'b1, 1'(m_y)});
    for (int s = 0; s < stall; s++) begin
      sync_a = NCH'($urandom) & ~onehot;
      mode_a = 1'($urandom); x_a = XW'($urandom); y_a = 1'($urandom);
      tick();
      check("rr_stall_notify", 32'(notify_a), 32'(onehot));
      check("rr_stall_x", 32'(ox_a), 32'(m_acc));
    end
    sync_a = NCH'($urandom) | onehot;
    mode_a = 1'b0;
    tick();
    m_ptr = (m_ptr + 1) % NCH;
    m_cnt = (m_cnt + 1) % 65536;
    check("rr_notify_clear", 32'(notify_a), 32'd0);
    check("rr_ptr", 32'(ptr_a), 32'(m_ptr));
    check("rr_cnt", 32'(cnt_a), 32'(m_cnt));
  endtask

  // one broadcast record; rise[i] = cycles after notify when sync[i] goes high
  task automatic bc_record(input int xv, input int r0, input int r1, input int r2, input int r3);
    int rise[NCH];
    int mx;
    logic [NCH-1:0] exp_n;
    rise[0] = r0; rise[1] = r1; rise[2] = r2; rise[3] = r3;
    mx = 1;
    for (int i = 0; i < NCH; i++) if (rise[i] > mx) mx = rise[i];
    sync_b = '0;
    for (int i = 0; i < NCH; i++) if (rise[i] == 0) sync_b[i] = 1'b1;
    mode_b = 1'b1; x_b = XW'(xv); y_b = 1'($urandom);
    tick();
    m_acc = (m_acc + xv) % 256;
    check("bc_notify_rise", 32'(notify_b), 32'hF);
    check("bc_x", 32'(ox_b), 32'(m_acc));
    for (int k = 1; k <= mx; k++) begin
      for (int i = 0; i < NCH; i++) sync_b[i] = (rise[i] <= k);
      mode_b = 1'($urandom); x_b = XW'($urandom); y_b = 1'($urandom);
      tick();
      exp_n = '0;
      for (int i = 0; i < NCH; i++) exp_n[i] = (rise[i] > k);
      check("bc_notify_step", 32'(notify_b), 32'(exp_n));
      if (k < mx) check("bc_cnt_hold", 32'(cnt_b), 32'(m_cnt));
      check("bc_x_hold", 32'(ox_b), 32'(m_acc));
    end
    m_cnt = (m_cnt + 1) % 65536;
    check("bc_cnt", 32'(cnt_b), 32'(m_cnt));
    check("bc_ptr", 32'(ptr_b), 32'd0);
    mode_b = 1'b0; y_b = 1'($urandom);
    tick();
    check("bc_idle_notify", 32'(notify_b), 32'd0);
    check("bc_idle_y", 32'(oy_b), 32'(y_b));
    sync_b = '0;
  endtask

  initial begin
    int xs[5];
    rst = 1'b1;
    mode_a = 0; x_a = '0; y_a = 0; sync_a = '0;
    mode_b = 0; x_b = '0; y_b = 0; sync_b = '0;
    m_acc = 0; m_ptr = 0; m_cnt = 0; m_y = 0;
    tick();
    check("reset_notify", 32'(notify_a), 32'd0);
    check("reset_cnt_ptr", {cnt_a, 14'd0, ptr_a}, 32'd0);
    tick();
    rst = 1'b0;

    // idle reads
    mode_a = 1'b0; y_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_notify", 32'(notify_a), 32'd0);
      check("idle_y", 32'(oy_a), 32'd1);
      check("idle_x", 32'(ox_a), 32'd0);
      check("idle_cnt", 32'(cnt_a), 32'd0);
    end

    // round-robin with sync held high throughout
    xs = '{5, 7, 1, 2, 3};
    sync_a = '1;
    for (int i = 0; i < 5; i++) rr_record(xs[i], 0);
    check("rr_plan_x", 32'(ox_a), 32'd18);
    check("rr_plan_cnt", 32'(cnt_a), 32'd5);

    // stall on channel 0
    do_reset();
    sync_a = '0;
    rr_record(9, 6);
    check("stall_x", 32'(ox_a), 32'd9);
    check("stall_ptr", 32'(ptr_a), 32'd1);

    // accumulator wrap
    do_reset();
    rr_record(8'hF0, 0);
    check("wrap_first", 32'(ox_a), 32'hF0);
    rr_record(8'h20, 0);
    check("wrap_second", 32'(ox_a), 32'h10);

    // async reset while channel 2 is notified
    do_reset();
    rr_record(1, 0);
    rr_record(1, 0);
    sync_a = '0; mode_a = 1'b1; x_a = 8'd3;
    tick();
    check("arst_pre_notify", 32'(notify_a), 32'h4);
    mode_a = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_notify", 32'(notify_a), 32'd0);
    check("arst_x", 32'(ox_a), 32'd0);
    check("arst_ptr", 32'(ptr_a), 32'd0);
    #1 rst = 1'b0;
    m_acc = 0; m_ptr = 0; m_cnt = 0;
    tick();
    sync_a = '1;
    rr_record(4, 0);
    check("arst_next_x", 32'(ox_a), 32'd4);

    // randomized round-robin
    do_reset();
    for (int r = 0; r < 40; r++) begin
      rr_record(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        mode_a = 1'b0; y_a = 1'($urandom); x_a = XW'($urandom);
        tick();
        check("rr_read_y", 32'(oy_a), 32'(y_a));
        check("rr_read_mode", 32'(omode_a), 32'd0);
        check("rr_read_x", 32'(ox_a), 32'(m_acc));
        check("rr_read_notify", 32'(notify_a), 32'd0);
      end
    end

    // broadcast directed: syncs rise 1, 3, 3, 5 cycles after notify
    do_reset();
    bc_record(6, 1, 3, 3, 5);
    check("bc_plan_cnt", 32'(cnt_b), 32'd1);

    // randomized broadcast
    for (int r = 0; r < 25; r++)
      bc_record(int'($urandom_range(0, 255)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
